mem_store_unit: RTL and testbench

- M-stage data-memory access unit for the P7 pipeline. Narrows and aligns store data into byte lanes with a byte-enable mask (the writer side, inverse of immediate/load widening).
- Runs a req/ack handshake to the bridge, extends load data back to 32 bits, and flags address-alignment exceptions.
- Sits between the M-stage pipeline register and the bridge/DM/timer bus. Holds `mem_busy` to stall the pipeline while an access is outstanding.

---
 rtl/mem_store_unit_pkg.sv | 36 +++
 rtl/mem_store_unit_lane_align.sv | 66 ++++++
 rtl/mem_store_unit.sv | 155 +++++++++++++++
 tb/tb_mem_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_unit_pkg.sv
// ============================================================================
// Module  : mem_store_unit_pkg
// Brief   : Op codes, exception codes and FSM states for the M-stage memory unit
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_store_unit_pkg;

    localparam logic [2:0] MEM_SW  = 3'd0;
    localparam logic [2:0] MEM_SH  = 3'd1;
    localparam logic [2:0] MEM_SB  = 3'd2;
    localparam logic [2:0] MEM_LW  = 3'd3;
    localparam logic [2:0] MEM_LH  = 3'd4;
    localparam logic [2:0] MEM_LHU = 3'd5;
    localparam logic [2:0] MEM_LB  = 3'd6;
    localparam logic [2:0] MEM_LBU = 3'd7;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op <= MEM_SB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_store_unit_lane_align.sv
// ============================================================================
// Module  : store_lane_align
// Brief   : Byte-lane steering for stores and load extension (combinational)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module store_lane_align
    import mem_store_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign w_byte = rdata[{addr_lo, 3'b000} +: 8];

    always_comb begin
        byteen    = 4'b0000;
        wdata_al  = wdata;
        rdata_ext = 32'd0;
        misalign  = 1'b0;
        case (op)
            MEM_SW: begin
                byteen   = 4'b1111;
                misalign = |addr_lo;
            end
            MEM_SH: begin
                byteen   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            MEM_SB: begin
                byteen   = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            MEM_LW: begin
                rdata_ext = rdata;
                misalign  = |addr_lo;
            end
            MEM_LH: begin
                rdata_ext = {{16{w_half[15]}}, w_half};
                misalign  = addr_lo[0];
            end
            MEM_LHU: begin
                rdata_ext = {16'd0, w_half};
                misalign  = addr_lo[0];
            end
            MEM_LB:  rdata_ext = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: rdata_ext = {24'd0, w_byte};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_store_unit.sv
// ============================================================================
// Module  : mem_store_unit
// Brief   : M-stage data-memory access unit: req/ack bus FSM, lane alignment,
//           load extension and alignment exceptions.
//           Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_byteen,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_exccode,
    output logic              mem_busy
);

    // The wait counter is 5 bits wide, so the limit must fit it.
    if (TIMEOUT < 2 || TIMEOUT > 32) begin : g_timeout_range
        $error("mem_store_unit: TIMEOUT must be in 2..32");
    end

    state_e      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;

    logic [2:0]  w_op;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata_al;
    logic [31:0] w_rdata_ext;
    logic        w_misalign;

`ifdef MEM_TIMEOUT_EN
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);
    logic [4:0] r_wait_cnt;
`endif

    // The aligner sees the incoming request in IDLE and the latched one afterwards.
    assign w_op      = (r_state == ST_IDLE) ? req_op        : r_op;
    assign w_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;

    store_lane_align u_align (
        .op        (w_op),
        .addr_lo   (w_addr_lo),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .byteen    (w_byteen),
        .wdata_al  (w_wdata_al),
        .rdata_ext (w_rdata_ext),
        .misalign  (w_misalign)
    );

    assign mem_busy = (r_state != ST_IDLE) | req_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'd0;
            r_addr_lo   <= 2'd0;
            req_ready   <= 1'b1;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_byteen  <= 4'b0000;
            bus_wdata   <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_exccode <= EXC_NONE;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt  <= 5'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_addr_lo <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (w_misalign) begin
                            r_state     <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= 32'd0;
                            rsp_exccode <= op_is_store(req_op) ? EXC_ADES : EXC_ADEL;
                        end else begin
                            r_state    <= ST_BUS;
                            bus_req    <= 1'b1;
                            bus_we     <= op_is_store(req_op);
                            bus_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_byteen <= w_byteen;
                            bus_wdata  <= w_wdata_al;
`ifdef MEM_TIMEOUT_EN
                            r_wait_cnt <= 5'd0;
`endif
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        r_state     <= ST_RESP;
                        bus_req     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= w_rdata_ext;
                        rsp_exccode <= EXC_NONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_wait_cnt == TMO_LAST) begin
                        r_state     <= ST_RESP;
                        bus_req     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'd0;
                        rsp_exccode <= EXC_DBE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 5'd1;
                    end
`endif
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    req_ready   <= 1'b1;
                    rsp_valid   <= 1'b0;
                    rsp_rdata   <= 32'd0;
                    rsp_exccode <= EXC_NONE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                    bus_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_store_unit.sv
// ============================================================================
// Module  : tb_mem_store_unit
// Brief   : Scoreboard bench for mem_store_unit with a randomized bus responder
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_store_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_exccode;
    logic        mem_busy;

    always #5 clk = ~clk;

    mem_store_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_byteen  (bus_byteen),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_exccode (rsp_exccode),
        .mem_busy    (mem_busy)
    );

    int     n_checks = 0;
    int     n_errs   = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  exc;
        longint      exp_cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    rsp_t sb_q[$];
    bus_t bus_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access size n at byte offset o; misaligned when o is not a multiple of n.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int delay);
        int          n;
        int          o;
        bit          st;
        bit          sgn;
        bit          mis;
        bit          ok;
        longint      c;
        logic [31:0] v;
        logic [31:0] mask;
        bus_t        b;
        rsp_t        r;
        n   = (op == 3'd0 || op == 3'd3) ? 4 : ((op == 3'd1 || op == 3'd4 || op == 3'd5) ? 2 : 1);
        o   = int'(addr % 4);
        st  = (op < 3'd3);
        sgn = (op == 3'd4 || op == 3'd6);
        mis = ((o % n) != 0);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        c = cyc;
        if (mis) begin
            r.rdata   = 32'd0;
            r.exc     = st ? 5'd5 : 5'd4;
            r.exp_cyc = c + 1;
        end else begin
            if (st) begin
                v = 32'd0;
            end else begin
                v = rd >> (8 * o);
                if (n < 4) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    v = v & mask;
                    if (sgn && v[8*n-1]) v = v | ~mask;
                end
            end
            r.rdata   = v;
            r.exc     = 5'd0;
            r.exp_cyc = c + 2 + delay;
`ifdef MEM_TIMEOUT_EN
            if (delay >= TIMEOUT) begin
                r.rdata   = 32'd0;
                r.exc     = 5'd7;
                r.exp_cyc = c + 1 + TIMEOUT;
            end
`endif
            b.we    = st;
            b.addr  = {addr[31:2], 2'b00};
            b.be    = 4'b0000;
            b.wd    = 32'd0;
            for (int i = 0; i < 4; i++) begin
                if (st && i >= o && i < o + n) b.be[i] = 1'b1;
                b.wd[8*i +: 8] = wd[8*(i % n) +: 8];
            end
            if (!st) b.wd = 32'hxxxx_xxxx;
            b.rdata = rd;
            b.delay = delay;
            bus_q.push_back(b);
        end
        sb_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // Bus responder: acks after the scheduled delay, random ack noise while bus_req is low.
    initial begin : bus_responder
        bus_t cur;
        bit   active;
        int   cnt;
        active = 1'b0;
        cnt    = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                active  = 1'b0;
                bus_ack = 1'b0;
            end else if (bus_req === 1'b1) begin
                if (!active && bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 32'd1, 32'd0);
                    bus_ack = 1'b0;
                end else begin
                    if (!active) begin
                        cur    = bus_q.pop_front();
                        active = 1'b1;
                        cnt    = 0;
                    end
                    chk("bus_we", 32'(bus_we), 32'(cur.we));
                    chk("bus_addr", bus_addr, cur.addr);
                    chk("bus_byteen", 32'(bus_byteen), 32'(cur.be));
                    if (cur.we) chk("bus_wdata", bus_wdata, cur.wd);
                    if (cnt == cur.delay) begin
                        bus_ack   = 1'b1;
                        bus_rdata = cur.rdata;
                    end else begin
                        bus_ack   = 1'b0;
                        bus_rdata = $urandom;
                    end
                    cnt++;
                end
            end else begin
                active    = 1'b0;
                bus_ack   = ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (req_valid) chk("busy_with_req", 32'(mem_busy), 32'd1);
                if (rsp_valid === 1'b1) begin
                    chk("busy_in_resp", 32'(mem_busy), 32'd1);
                    chk("ready_in_resp", 32'(req_ready), 32'd0);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        r = sb_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                        chk("rsp_exccode", 32'(rsp_exccode), 32'(r.exc));
                        chk("rsp_cycle", 32'(cyc), 32'(r.exp_cyc));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [2:0]  op;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_mem_busy", 32'(mem_busy), 32'd0);
        chk("reset_byteen", 32'(bus_byteen), 32'd0);
        chk("reset_exccode", 32'(rsp_exccode), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(3'd2, 32'h0000_0013, 32'h1234_56AB, 32'h0, 3);
        idle(1);
        issue(3'd4, 32'h0000_0022, 32'h0, 32'h8001_FFFF, 0);
        idle(1);
        issue(3'd5, 32'h0000_0022, 32'h0, 32'h8001_FFFF, 0);
        idle(1);
        issue(3'd0, 32'h0000_0006, 32'hDEAD_BEEF, 32'h0, 0);
        idle(1);
        issue(3'd3, 32'h0000_0006, 32'h0, 32'h1111_2222, 0);
        idle(1);
        issue(3'd0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 2);
        issue(3'd3, 32'h0000_0044, 32'h0, 32'h5A5A_A5A5, 1);
        issue(3'd1, 32'h0000_0046, 32'h0000_BEEF, 32'h0, 0);
        idle(2);
`ifdef MEM_TIMEOUT_EN
        issue(3'd3, 32'h0000_0080, 32'h0, 32'h7777_7777, 255);
        idle(1);
        issue(3'd3, 32'h0000_0080, 32'h0, 32'h7777_7777, TIMEOUT - 1);
        idle(1);
`endif
        drain();

        for (int k = 0; k < 150; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 3'd0 || op == 3'd3) a[1:0] = 2'b00;
                else if (op == 3'd1 || op == 3'd4 || op == 3'd5) a[0] = 1'b0;
            end
            issue(op, a, $urandom, $urandom, $urandom_range(0, 5));
            idle($urandom_range(0, 2));
        end
        drain();

        issue(3'd3, 32'h0000_0100, 32'h0, 32'h1234_5678, 40);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_bus_req", 32'(bus_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_bus_req_drop", 32'(bus_req), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd1);
        sb_q.delete();
        bus_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        idle(4);
        issue(3'd6, 32'h0000_0203, 32'h0, 32'h80FF_0102, 1);
        idle(1);
        issue(3'd7, 32'h0000_0203, 32'h0, 32'h80FF_0102, 0);
        idle(1);
        drain();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
